// File: rtl/rf_wb_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
// Requester indices, widths and the one-hot to index encoder live here.
package rf_wb_pkg;

   localparam int NUM_REQ   = 3;
   localparam int REQ_ALU   = 0;
   localparam int REQ_LSU   = 1;
   localparam int REQ_MDU   = 2;
   localparam int TAG_W_DEF = 2;
   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 32;

   typedef logic [1:0]         req_idx_t;
   typedef logic [NUM_REQ-1:0] req_vec_t;

   // last_grant after reset: the MDU, so the ALU is served first
   localparam req_idx_t LAST_RST = req_idx_t'(REQ_MDU);

   function automatic req_idx_t oh_to_idx(input req_vec_t oh);
      req_idx_t idx;
      idx = '0;
      unique case (1'b1)
         oh[REQ_ALU]: idx = req_idx_t'(REQ_ALU);
         oh[REQ_LSU]: idx = req_idx_t'(REQ_LSU);
         oh[REQ_MDU]: idx = req_idx_t'(REQ_MDU);
         default:     idx = '0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus: three requester channels, flush, one RF write port.
// master = requesters/RF side, slave = the arbiter.
interface rf_wb_arbiter_if #(
   parameter int TAG_WIDTH = rf_wb_pkg::TAG_W_DEF
);
   import rf_wb_pkg::*;

   logic                 req0_valid;
   logic                 req0_ready;
   logic [ADDR_W-1:0]    req0_addr;
   logic [TAG_WIDTH-1:0] req0_tag;
   logic [DATA_W-1:0]    req0_data;

   logic                 req1_valid;
   logic                 req1_ready;
   logic [ADDR_W-1:0]    req1_addr;
   logic [TAG_WIDTH-1:0] req1_tag;
   logic [DATA_W-1:0]    req1_data;

   logic                 req2_valid;
   logic                 req2_ready;
   logic [ADDR_W-1:0]    req2_addr;
   logic [TAG_WIDTH-1:0] req2_tag;
   logic [DATA_W-1:0]    req2_data;

   logic                 flush;

   logic                 wr_ch0_en;
   logic [ADDR_W-1:0]    wr_ch0_addr;
   logic [TAG_WIDTH-1:0] wr_ch0_tag;
   logic [DATA_W-1:0]    wr_ch0_data;

   logic                 busy;

   modport master (
      output req0_valid, req0_addr, req0_tag, req0_data,
      output req1_valid, req1_addr, req1_tag, req1_data,
      output req2_valid, req2_addr, req2_tag, req2_data,
      output flush,
      input  req0_ready, req1_ready, req2_ready,
      input  wr_ch0_en, wr_ch0_addr, wr_ch0_tag, wr_ch0_data,
      input  busy
   );

   modport slave (
      input  req0_valid, req0_addr, req0_tag, req0_data,
      input  req1_valid, req1_addr, req1_tag, req1_data,
      input  req2_valid, req2_addr, req2_tag, req2_data,
      input  flush,
      output req0_ready, req1_ready, req2_ready,
      output wr_ch0_en, wr_ch0_addr, wr_ch0_tag, wr_ch0_data,
      output busy
   );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb3.sv
// Three-way round-robin arbiter, purely combinational.
// Priority begins just after last_i and wraps 2 -> 0.
module rr_arb3
   import rf_wb_pkg::*;
(
   input  req_vec_t req_i,
   input  req_idx_t last_i,
   output req_vec_t grant_o
);

   // pick the first requesting bit in rotated priority order
   always_comb begin
      grant_o = '0;
      unique case (last_i)
         2'd0: begin
            if      (req_i[1]) grant_o = 3'b010;
            else if (req_i[2]) grant_o = 3'b100;
            else if (req_i[0]) grant_o = 3'b001;
         end
         2'd1: begin
            if      (req_i[2]) grant_o = 3'b100;
            else if (req_i[0]) grant_o = 3'b001;
            else if (req_i[1]) grant_o = 3'b010;
         end
         default: begin
            if      (req_i[0]) grant_o = 3'b001;
            else if (req_i[1]) grant_o = 3'b010;
            else if (req_i[2]) grant_o = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: one buffer per requester, round-robin grant,
// registered single RF write port. Addr-0 writes are consumed silently.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int TAG_WIDTH = TAG_W_DEF
) (
   input logic           clk,
   input logic           reset_n,
   rf_wb_arbiter_if.slave bus
);

   typedef logic [TAG_WIDTH-1:0] tag_t;
   typedef logic [ADDR_W-1:0]    addr_t;
   typedef logic [DATA_W-1:0]    data_t;

   req_vec_t in_valid;
   req_vec_t in_ready;
   req_vec_t accept;
   addr_t    in_addr [NUM_REQ];
   tag_t     in_tag  [NUM_REQ];
   data_t    in_data [NUM_REQ];

   req_vec_t buf_valid_q, buf_valid_d;
   addr_t    buf_addr_q [NUM_REQ];
   addr_t    buf_addr_d [NUM_REQ];
   tag_t     buf_tag_q  [NUM_REQ];
   tag_t     buf_tag_d  [NUM_REQ];
   data_t    buf_data_q [NUM_REQ];
   data_t    buf_data_d [NUM_REQ];

   req_idx_t last_q, last_d;

   logic     out_valid_q, out_valid_d;
   addr_t    out_addr_q, out_addr_d;
   tag_t     out_tag_q, out_tag_d;
   data_t    out_data_q, out_data_d;

   req_vec_t arb_req;
   req_vec_t grant;
   req_idx_t gidx;

   // gather the named requester channels into indexable arrays
   always_comb begin
      in_valid = {bus.req2_valid, bus.req1_valid, bus.req0_valid};
      in_addr[REQ_ALU] = bus.req0_addr;
      in_addr[REQ_LSU] = bus.req1_addr;
      in_addr[REQ_MDU] = bus.req2_addr;
      in_tag[REQ_ALU]  = bus.req0_tag;
      in_tag[REQ_LSU]  = bus.req1_tag;
      in_tag[REQ_MDU]  = bus.req2_tag;
      in_data[REQ_ALU] = bus.req0_data;
      in_data[REQ_LSU] = bus.req1_data;
      in_data[REQ_MDU] = bus.req2_data;
   end

   assign arb_req = bus.flush ? '0 : buf_valid_q;

   rr_arb3 u_arb (
      .req_i   (arb_req),
      .last_i  (last_q),
      .grant_o (grant)
   );

   // a buffer being drained this cycle may be refilled at the same edge
   assign in_ready = {NUM_REQ{~bus.flush}} & (~buf_valid_q | grant);
   assign accept   = in_valid & in_ready;

   assign bus.req0_ready = in_ready[REQ_ALU];
   assign bus.req1_ready = in_ready[REQ_LSU];
   assign bus.req2_ready = in_ready[REQ_MDU];

   // next state for buffers, round-robin pointer and output stage
   always_comb begin
      gidx = oh_to_idx(grant);
      for (int k = 0; k < NUM_REQ; k++) begin
         buf_addr_d[k] = buf_addr_q[k];
         buf_tag_d[k]  = buf_tag_q[k];
         buf_data_d[k] = buf_data_q[k];
         if (bus.flush)
            buf_valid_d[k] = 1'b0;
         else if (accept[k])
            buf_valid_d[k] = 1'b1;
         else if (grant[k])
            buf_valid_d[k] = 1'b0;
         else
            buf_valid_d[k] = buf_valid_q[k];
         if (accept[k]) begin
            buf_addr_d[k] = in_addr[k];
            buf_tag_d[k]  = in_tag[k];
            buf_data_d[k] = in_data[k];
         end
      end
      last_d      = last_q;
      out_valid_d = |grant;
      out_addr_d  = out_addr_q;
      out_tag_d   = out_tag_q;
      out_data_d  = out_data_q;
      if (|grant) begin
         last_d     = gidx;
         out_addr_d = buf_addr_q[gidx];
         out_tag_d  = buf_tag_q[gidx];
         out_data_d = buf_data_q[gidx];
      end
   end

   // register all state; reset drops every in-flight entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_valid_q <= '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            buf_addr_q[k] <= '0;
            buf_tag_q[k]  <= '0;
            buf_data_q[k] <= '0;
         end
         last_q      <= LAST_RST;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_tag_q   <= '0;
         out_data_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         for (int k = 0; k < NUM_REQ; k++) begin
            buf_addr_q[k] <= buf_addr_d[k];
            buf_tag_q[k]  <= buf_tag_d[k];
            buf_data_q[k] <= buf_data_d[k];
         end
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_tag_q   <= out_tag_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.wr_ch0_en   = out_valid_q & (out_addr_q != '0);
   assign bus.wr_ch0_addr = out_addr_q;
   assign bus.wr_ch0_tag  = out_tag_q;
   assign bus.wr_ch0_data = out_data_q;
   assign bus.busy        = (|buf_valid_q) | out_valid_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rf_wb_arbiter;
   import rf_wb_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad = 0;

   rf_wb_arbiter_if #(.TAG_WIDTH(2)) bus ();

   rf_wb_arbiter #(.TAG_WIDTH(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.req0_valid = 1'b0; bus.req0_addr = '0;
      bus.req0_tag = '0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_addr = '0;
      bus.req1_tag = '0; bus.req1_data = '0;
      bus.req2_valid = 1'b0; bus.req2_addr = '0;
      bus.req2_tag = '0; bus.req2_data = '0;
      bus.flush = 1'b0;
   endtask

   task automatic set_req(input int k, input logic v,
                          input logic [4:0] a, input logic [1:0] t,
                          input logic [31:0] d);
      case (k)
         0: begin
            bus.req0_valid = v; bus.req0_addr = a;
            bus.req0_tag = t; bus.req0_data = d;
         end
         1: begin
            bus.req1_valid = v; bus.req1_addr = a;
            bus.req1_tag = t; bus.req1_data = d;
         end
         default: begin
            bus.req2_valid = v; bus.req2_addr = a;
            bus.req2_tag = t; bus.req2_data = d;
         end
      endcase
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic chk_en(input string nm, input logic exp);
      total++;
      if (bus.wr_ch0_en !== exp) begin
         bad++;
         $display("FAIL %s wr_en got=%b exp=%b", nm, bus.wr_ch0_en, exp);
      end
   endtask

   task automatic chk_wr(input string nm, input logic [4:0] a,
                         input logic [1:0] t, input logic [31:0] d);
      total++;
      if (bus.wr_ch0_en !== 1'b1 || bus.wr_ch0_addr !== a ||
          bus.wr_ch0_tag !== t || bus.wr_ch0_data !== d) begin
         bad++;
         $display("FAIL %s got en=%b a=%0d t=%0d d=%h exp en=1 a=%0d t=%0d d=%h",
                  nm, bus.wr_ch0_en, bus.wr_ch0_addr, bus.wr_ch0_tag,
                  bus.wr_ch0_data, a, t, d);
      end
   endtask

   task automatic chk_busy(input string nm, input logic exp);
      total++;
      if (bus.busy !== exp) begin
         bad++;
         $display("FAIL %s busy got=%b exp=%b", nm, bus.busy, exp);
      end
   endtask

   task automatic chk_ready(input string nm, input logic [2:0] exp);
      logic [2:0] got;
      got = {bus.req2_ready, bus.req1_ready, bus.req0_ready};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s ready got=%b exp=%b", nm, got, exp);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      #1;
      chk_en("reset", 1'b0);
      chk_busy("reset", 1'b0);
      total++;
      if (bus.wr_ch0_addr !== 5'd0 || bus.wr_ch0_tag !== 2'd0 ||
          bus.wr_ch0_data !== 32'd0) begin
         bad++;
         $display("FAIL reset_out got a=%0d t=%0d d=%h exp 0",
                  bus.wr_ch0_addr, bus.wr_ch0_tag, bus.wr_ch0_data);
      end
      reset_n = 1'b1;
      #1;
      chk_ready("reset_rel", 3'b111);
      @(negedge clk);
   endtask

   task automatic test_single();
      do_reset();
      set_req(1, 1'b1, 5'd5, 2'd1, 32'hDEADBEEF);
      #1;
      chk_ready("single_c0", 3'b111);
      @(negedge clk);
      set_req(1, 1'b0, 5'd0, 2'd0, 32'd0);
      chk_en("single_c1", 1'b0);
      chk_busy("single_c1", 1'b1);
      @(negedge clk);
      chk_wr("single_c2", 5'd5, 2'd1, 32'hDEADBEEF);
      @(negedge clk);
      chk_en("single_c3", 1'b0);
      @(negedge clk);
      chk_en("single_c4", 1'b0);
      chk_busy("single_c4", 1'b0);
   endtask

   task automatic test_contention();
      logic [4:0] exp_a [6];
      exp_a = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
      do_reset();
      set_req(0, 1'b1, 5'd1, 2'd1, 32'h11);
      set_req(1, 1'b1, 5'd2, 2'd2, 32'h22);
      set_req(2, 1'b1, 5'd3, 2'd3, 32'h33);
      @(negedge clk);
      chk_en("cont_c1", 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk_wr($sformatf("cont_w%0d", i), exp_a[i], exp_a[i][1:0],
                32'h11 * exp_a[i]);
      end
      idle_inputs();
   endtask

   task automatic test_addr0();
      do_reset();
      set_req(0, 1'b1, 5'd0, 2'd2, 32'h0);
      @(negedge clk);
      set_req(0, 1'b1, 5'd7, 2'd3, 32'h7777);
      set_req(1, 1'b1, 5'd9, 2'd1, 32'h9999);
      #1;
      chk_ready("a0_refill", 3'b111);
      @(negedge clk);
      idle_inputs();
      chk_en("a0_zero", 1'b0);
      chk_busy("a0_zero", 1'b1);
      @(negedge clk);
      chk_wr("a0_req1", 5'd9, 2'd1, 32'h9999);
      @(negedge clk);
      chk_wr("a0_req0", 5'd7, 2'd3, 32'h7777);
      @(negedge clk);
      chk_en("a0_end", 1'b0);
   endtask

   task automatic test_flush();
      do_reset();
      set_req(0, 1'b1, 5'd1, 2'd1, 32'h11);
      set_req(1, 1'b1, 5'd2, 2'd2, 32'h22);
      set_req(2, 1'b1, 5'd3, 2'd3, 32'h33);
      @(negedge clk);
      set_req(0, 1'b1, 5'd4, 2'd0, 32'h44);
      set_req(1, 1'b1, 5'd5, 2'd0, 32'h55);
      set_req(2, 1'b1, 5'd6, 2'd0, 32'h66);
      bus.flush = 1'b1;
      #1;
      chk_ready("fl_ready", 3'b000);
      @(negedge clk);
      idle_inputs();
      chk_en("fl_c2", 1'b0);
      chk_busy("fl_c2", 1'b0);
      @(negedge clk);
      chk_en("fl_c3", 1'b0);
      chk_busy("fl_c3", 1'b0);
      set_req(0, 1'b1, 5'd4, 2'd0, 32'h44);
      set_req(1, 1'b1, 5'd5, 2'd1, 32'h55);
      @(negedge clk);
      idle_inputs();
      chk_en("fl_c4", 1'b0);
      @(negedge clk);
      chk_wr("fl_after0", 5'd4, 2'd0, 32'h44);
      @(negedge clk);
      chk_wr("fl_after1", 5'd5, 2'd1, 32'h55);
   endtask

   task automatic test_reset_midop();
      do_reset();
      set_req(0, 1'b1, 5'd1, 2'd1, 32'h11);
      set_req(1, 1'b1, 5'd2, 2'd2, 32'h22);
      set_req(2, 1'b1, 5'd3, 2'd3, 32'h33);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      chk_wr("mid_pre", 5'd1, 2'd1, 32'h11);
      reset_n = 1'b0;
      #1;
      chk_en("mid_rst", 1'b0);
      chk_busy("mid_rst", 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk_ready("mid_rel", 3'b111);
      @(negedge clk);
      chk_en("mid_q1", 1'b0);
      chk_busy("mid_q1", 1'b0);
      @(negedge clk);
      chk_en("mid_q2", 1'b0);
      set_req(0, 1'b1, 5'd12, 2'd0, 32'hC0C0);
      set_req(1, 1'b1, 5'd11, 2'd3, 32'hB0B0);
      @(negedge clk);
      idle_inputs();
      chk_en("mid_q3", 1'b0);
      @(negedge clk);
      chk_wr("mid_first", 5'd12, 2'd0, 32'hC0C0);
      @(negedge clk);
      chk_wr("mid_second", 5'd11, 2'd3, 32'hB0B0);
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_contention();
      test_addr0();
      test_flush();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 2, the register-tag width matching the register file.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports reqK_valid  input  1  writeback request from requester K (K=0 ALU, 1 LSU, 2 MDU).
REQ-005 SHALL have ports reqK_ready  output  1  requester K's buffer can accept this cycle.
REQ-006 SHALL have ports reqK_addr  input  5, reqK_tag  input  TAG_WIDTH, reqK_data  input  32  destination register, tag and result.
REQ-007 SHALL have port flush  input  1  synchronous drop of all pending writebacks.
REQ-008 SHALL have ports wr_ch0_en  output  1, wr_ch0_addr  output  5, wr_ch0_tag  output  TAG_WIDTH, wr_ch0_data  output  32  single register-file write port.
REQ-009 SHALL have port busy  output  1  any buffer or the output stage holds a valid entry.

Function
REQ-010 SHALL hold one input buffer per requester (valid, addr, tag, data), loaded when reqK_valid & reqK_ready.
REQ-011 SHALL drive reqK_ready = ~flush & (~bufK_valid | grantK); a granted buffer refills in the same cycle.
REQ-012 SHALL grant at most one valid buffer per cycle, round-robin: priority starts at (last_grant+1) mod 3 and wraps 2->0.
REQ-013 SHALL update last_grant only in cycles with a grant; it holds when no buffer is valid.
REQ-014 SHALL move the granted entry into an output register; wr_ch0_* reflect it the next cycle, so accept at cycle N gives wr_ch0_en at N+2.
REQ-015 SHALL deassert wr_ch0_en in any cycle after a cycle with no grant; wr_ch0_addr/tag/data SHALL hold their last values then.
REQ-016 SHALL grant and consume an entry with addr 0 normally, advancing last_grant, but never assert wr_ch0_en for it.
REQ-017 SHALL sustain one write per cycle when requests are continuous; no bubble between back-to-back grants.
REQ-018 SHALL, on flush, make no grant that cycle, clear all buffer valids and the output valid at the next edge, and leave last_grant unchanged.
REQ-019 SHALL pass each entry's tag through unmodified; tag matching against the register file is not done here.
REQ-020 SHALL drive busy = |buf_valid | out_valid.

Reset
REQ-021 SHALL clear on reset_n low: all buffer valids, the output valid and wr_ch0_en; last_grant = 2, so requester 0 has first priority.
REQ-022 SHALL reset wr_ch0_addr, wr_ch0_tag and wr_ch0_data to 0, and reqK_ready SHALL be 1 after release.
REQ-023 SHALL discard any in-flight entry when reset is asserted mid-operation; no write occurs after release until a new accept.

Structure
REQ-024 SHALL take the requester count (3), requester index constants and the TAG_WIDTH default from the shared package rf_wb_pkg.
REQ-025 SHALL implement the grant logic as the sub-module rr_arb3 (3 request bits and last_grant in, one-hot grant out).

Verification
REQ-026 Single request: req1 addr=5 tag=1 data=0xDEADBEEF at cycle 0 -> wr_ch0_en=1, addr=5, tag=1, data=0xDEADBEEF at cycle 2, otherwise 0.
REQ-027 Contention: all three requesters hold valid from reset, addr 1/2/3 -> writes appear in order 1,2,3,1,2,3 on consecutive cycles with no gaps.
REQ-028 Addr 0: req0 addr=0 then req0 addr=7 -> only one wr_ch0_en pulse (addr=7), and req1 is granted before req0's second entry when both pend.
REQ-029 Flush: three buffers full, flush asserted one cycle -> no wr_ch0_en in the two following cycles, busy=0, ready=0 during the flush cycle.
REQ-030 Reset mid-op: assert reset_n=0 while the output stage is valid -> wr_ch0_en=0 immediately, and last_grant=2, so requester 0 wins first after release.
